// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID-stage hazard scoreboard.
// Types and constants only; no timing or flow-control behaviour of its own.
package pipe_pkg;

    localparam int HZ_REG_W = 5;
    localparam int HZ_DEPTH = 3;
    localparam logic [HZ_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } hz_entry_t;

    function automatic logic is_producer(input hz_entry_t e);
        return e.valid && e.reg_write && (e.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bundle: decoded register usage in, stall/bubble/counter out.
// Purely wires; the master drives the ID-side fields, the slave drives stall controls.
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_flush;
    logic             stall;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        input  stall, id_ex_bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        output stall, id_ex_bubble, stall_count
    );
endinterface

// File: rtl/hazard_match.sv
// Compares one ID source register against one shadow entry that produces a result.
// Latency: combinational; backpressure: none, pure function of its inputs.
module hazard_match
    import pipe_pkg::*;
(
    input  hz_entry_t           i_entry,
    input  logic [HZ_REG_W-1:0] i_rs,
    input  logic                i_use,
    output logic                o_match
);

    // x0 is hardwired, so reading it never depends on anything in flight.
    assign o_match = i_use && (i_rs != REG_ZERO) && is_producer(i_entry) && (i_rs == i_entry.rd);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall controller with an EX/MEM/WB shadow scoreboard; MEM_FWD_EN limits stalls to load-use.
// Latency: stall/bubble combinational, scoreboard and stall_count update 1 cycle; ex_flush overrides stall.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
)
(
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  hz
);

`ifdef MEM_FWD_EN
    localparam int N_CHK = 1;
`else
    localparam int N_CHK = 2;
`endif

    hz_entry_t        r_sb [HZ_DEPTH];
    logic [CNT_W-1:0] r_stall_count;

    hz_entry_t        w_id_entry;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [REG_W-1:0] w_rd;
    logic             w_use1;
    logic             w_use2;
    logic [N_CHK-1:0] w_m1;
    logic [N_CHK-1:0] w_m2;
    logic             w_hazard;
    logic             w_stall;
    logic             w_issue;

    assign w_rs1  = hz.id_rs1;
    assign w_rs2  = hz.id_rs2;
    assign w_rd   = hz.id_rd;
    assign w_use1 = hz.id_valid && hz.id_use_rs1;
    assign w_use2 = hz.id_valid && hz.id_use_rs2;

    // Entry 0 is EX, 1 is MEM; WB is tracked but never checked since MEM/WB forwarding covers it.
    for (genvar g = 0; g < N_CHK; g++) begin : g_chk
        hazard_match u_match_rs1 (
            .i_entry (r_sb[g]),
            .i_rs    (w_rs1),
            .i_use   (w_use1),
            .o_match (w_m1[g])
        );
        hazard_match u_match_rs2 (
            .i_entry (r_sb[g]),
            .i_rs    (w_rs2),
            .i_use   (w_use2),
            .o_match (w_m2[g])
        );
    end

`ifdef MEM_FWD_EN
    assign w_hazard = (w_m1[0] || w_m2[0]) && r_sb[0].mem_read;
`else
    assign w_hazard = (|w_m1) || (|w_m2);
`endif

    assign w_stall = w_hazard && !hz.ex_flush;
    assign w_issue = hz.id_valid && !w_stall && !hz.ex_flush;

    assign hz.stall        = w_stall;
    assign hz.id_ex_bubble = w_stall || hz.ex_flush || !hz.id_valid;
    assign hz.stall_count  = r_stall_count;

    always_comb begin
        w_id_entry = '0;
        if (w_issue) begin
            w_id_entry.valid     = 1'b1;
            w_id_entry.rd        = w_rd;
            w_id_entry.reg_write = hz.id_reg_write;
            w_id_entry.mem_read  = hz.id_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HZ_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= w_id_entry;
            for (int i = 1; i < HZ_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; expected stall counts follow the MEM_FWD_EN build choice.
module tb_hazard_stall_unit;

`ifdef MEM_FWD_EN
    localparam int EXP_ALU  = 0;
    localparam int EXP_LU   = 1;
    localparam int EXP_D2   = 0;
    localparam int EXP_DUAL = 0;
`else
    localparam int EXP_ALU  = 2;
    localparam int EXP_LU   = 2;
    localparam int EXP_D2   = 1;
    localparam int EXP_DUAL = 2;
`endif

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    hazard_stall_unit_if #(.REG_W(5), .CNT_W(4)) hz ();

    hazard_stall_unit #(.REG_W(5), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_use_rs1   = u1;
        hz.id_use_rs2   = u2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
        hz.ex_flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] r1;
        logic [4:0] r2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 1'b1, 1'b1,
                  5'($urandom_range(1, 31)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        vecs++;
        if (hz.stall !== 1'b0) begin
            errs++; $display("FAIL reset_stall: got %b want 0", hz.stall);
        end
        vecs++;
        if (hz.stall_count !== 4'd0) begin
            errs++; $display("FAIL reset_count: got %0d want 0", hz.stall_count);
        end
        rst = 1'b0;
        idle();
        #1;
        vecs++;
        if (hz.id_ex_bubble !== 1'b1 || hz.stall !== 1'b0) begin
            errs++; $display("FAIL reset_idle_bubble: bubble=%b stall=%b want 1 0", hz.id_ex_bubble, hz.stall);
        end
        r1 = 5'($urandom_range(1, 31));
        r2 = 5'($urandom_range(1, 31));
        drive(1'b1, r1, r2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.id_ex_bubble !== 1'b0) begin
            errs++; $display("FAIL reset_entries_invalid: stall=%b bubble=%b want 0 0", hz.stall, hz.id_ex_bubble);
        end
    endtask

    task automatic test_raw_alu();
        logic es;
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.id_ex_bubble !== 1'b0) begin
            errs++; $display("FAIL raw_alu_producer: stall=%b bubble=%b want 0 0", hz.stall, hz.id_ex_bubble);
        end
        tick();
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= EXP_ALU; i++) begin
            #1;
            es = (i < EXP_ALU);
            vecs++;
            if (hz.stall !== es || hz.id_ex_bubble !== es) begin
                errs++; $display("FAIL raw_alu_cycle%0d: stall=%b bubble=%b want %b %b", i, hz.stall, hz.id_ex_bubble, es, es);
            end
            tick();
        end
        idle();
        #1;
        vecs++;
        if (hz.stall_count !== 4'(EXP_ALU)) begin
            errs++; $display("FAIL raw_alu_count: got %0d want %0d", hz.stall_count, EXP_ALU);
        end
    endtask

    task automatic test_load_use();
        logic es;
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= EXP_LU; i++) begin
            #1;
            es = (i < EXP_LU);
            vecs++;
            if (hz.stall !== es || hz.id_ex_bubble !== es) begin
                errs++; $display("FAIL load_use_cycle%0d: stall=%b bubble=%b want %b %b", i, hz.stall, hz.id_ex_bubble, es, es);
            end
            tick();
        end
        idle();
        #1;
        vecs++;
        if (hz.stall_count !== 4'(EXP_LU)) begin
            errs++; $display("FAIL load_use_count: got %0d want %0d", hz.stall_count, EXP_LU);
        end
    endtask

    task automatic test_distance();
        logic es;
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= EXP_D2; i++) begin
            #1;
            es = (i < EXP_D2);
            vecs++;
            if (hz.stall !== es) begin
                errs++; $display("FAIL dist2_cycle%0d: stall=%b want %b", i, hz.stall, es);
            end
            tick();
        end
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0) begin
            errs++; $display("FAIL dist3: stall=%b want 0", hz.stall);
        end
    endtask

    task automatic test_dual_source();
        logic es;
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= EXP_DUAL; i++) begin
            #1;
            es = (i < EXP_DUAL);
            vecs++;
            if (hz.stall !== es) begin
                errs++; $display("FAIL dual_cycle%0d: stall=%b want %b", i, hz.stall, es);
            end
            tick();
        end
        idle();
        #1;
        vecs++;
        if (hz.stall_count !== 4'(EXP_DUAL)) begin
            errs++; $display("FAIL dual_count: got %0d want %0d", hz.stall_count, EXP_DUAL);
        end
    endtask

    task automatic test_x0_and_unused();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.id_ex_bubble !== 1'b0) begin
            errs++; $display("FAIL x0_consumer: stall=%b bubble=%b want 0 0", hz.stall, hz.id_ex_bubble);
        end
        tick();
        drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0) begin
            errs++; $display("FAIL unused_rs2: stall=%b want 0", hz.stall);
        end
        drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b1) begin
            errs++; $display("FAIL used_rs2_load: stall=%b want 1", hz.stall);
        end
        drive(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.id_ex_bubble !== 1'b1) begin
            errs++; $display("FAIL invalid_id: stall=%b bubble=%b want 0 1", hz.stall, hz.id_ex_bubble);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1);
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.id_ex_bubble !== 1'b1) begin
            errs++; $display("FAIL flush_wins: stall=%b bubble=%b want 0 1", hz.stall, hz.id_ex_bubble);
        end
        tick();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b0) begin
            errs++; $display("FAIL flush_ex_invalid: stall=%b want 0", hz.stall);
        end
        vecs++;
        if (hz.stall_count !== 4'd0) begin
            errs++; $display("FAIL flush_count: got %0d want 0", hz.stall_count);
        end
    endtask

    task automatic test_saturation();
        int n_iter;
        int e;
        n_iter = (21 + EXP_LU - 1) / EXP_LU;
        do_reset();
        for (int k = 1; k <= n_iter; k++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
            repeat (EXP_LU) tick();
            #1;
            e = k * EXP_LU;
            if (e > 15) e = 15;
            vecs++;
            if (hz.stall_count !== 4'(e)) begin
                errs++; $display("FAIL sat_iter%0d: got %0d want %0d", k, hz.stall_count, e);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++;
        if (hz.stall !== 1'b1) begin
            errs++; $display("FAIL async_pre: stall=%b want 1", hz.stall);
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if (hz.stall !== 1'b0 || hz.stall_count !== 4'd0) begin
            errs++; $display("FAIL async_reset: stall=%b count=%0d want 0 0", hz.stall, hz.stall_count);
        end
        tick();
        rst = 1'b0;
        #1;
        vecs++;
        if (hz.stall !== 1'b0) begin
            errs++; $display("FAIL async_release: stall=%b want 0", hz.stall);
        end
        idle();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b0;
        idle();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_distance();
        test_dual_source();
        test_x0_and_unused();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
